gaussian_kxk_core: RTL

Parametrised successor to the fixed 5x5 Gaussian core: a KSIZE x KSIZE separable-or-arbitrary smoothing convolver with internal column shift registers, a runtime-programmable coefficient bank, programmable normalisation, rounding and saturation. It sits after the line buffer. Each accepted valid cycle it consumes one KSIZE-tall pixel column and produces one filtered pixel through a fixed 3-stage pipeline. Line-start handling suppresses partial windows, and coefficient updates are applied atomically at line boundaries.

---
 rtl/gaussian_kxk_core_if.sv | 44 ++++
 rtl/gaussian_kxk_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_kxk_core_if.sv
// gaussian_kxk_core_if
//   Bundles the pixel stream, control and coefficient-programming signals
//   of gaussian_kxk_core into one interface.
//   master : the upstream driver (line buffer + register block)
//   slave  : the convolver core
//   Driven by master: enable, valid_in, sol, win_col, bypass, coeff_wr_en,
//                     coeff_wr_addr, coeff_wr_data, shift_wr_en,
//                     shift_wr_data, coeff_commit
//   Driven by slave : coeff_pending, pixel_out, valid_out
interface gaussian_kxk_core_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int KSIZE       = 5,
    parameter int COEFF_WIDTH = 10,
    parameter int SHIFT_WIDTH = 5
);
    logic                           enable;
    logic                           valid_in;
    logic                           sol;
    logic [KSIZE*PIXEL_WIDTH-1:0]   win_col;
    logic                           bypass;
    logic                           coeff_wr_en;
    logic [5:0]                     coeff_wr_addr;
    logic [COEFF_WIDTH-1:0]         coeff_wr_data;
    logic                           shift_wr_en;
    logic [SHIFT_WIDTH-1:0]         shift_wr_data;
    logic                           coeff_commit;
    logic                           coeff_pending;
    logic [PIXEL_WIDTH-1:0]         pixel_out;
    logic                           valid_out;

    modport master (
        output enable, valid_in, sol, win_col, bypass,
        output coeff_wr_en, coeff_wr_addr, coeff_wr_data,
        output shift_wr_en, shift_wr_data, coeff_commit,
        input  coeff_pending, pixel_out, valid_out
    );

    modport slave (
        input  enable, valid_in, sol, win_col, bypass,
        input  coeff_wr_en, coeff_wr_addr, coeff_wr_data,
        input  shift_wr_en, shift_wr_data, coeff_commit,
        output coeff_pending, pixel_out, valid_out
    );
endinterface

// File: rtl/gaussian_kxk_core.sv
// gaussian_kxk_core
//   KSIZE x KSIZE smoothing convolver. Each accepted column is shifted into
//   a per-row window; complete windows are multiplied by the active
//   coefficient bank (stage 1), summed (stage 2), then rounded, shifted and
//   saturated (stage 3). Coefficients/shift are written into a shadow bank
//   and swapped into the active bank at the first line start after a
//   commit request.
//   Ports: clk, rst_n (async active-low), bus (gaussian_kxk_core_if.slave).
module gaussian_kxk_core #(
    parameter int PIXEL_WIDTH = 8,
    parameter int KSIZE       = 5,
    parameter int COEFF_WIDTH = 10,
    parameter int ACCUM_WIDTH = 24,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    gaussian_kxk_core_if.slave bus
);
    localparam int NTAP   = KSIZE * KSIZE;
    localparam int CTR    = ((KSIZE - 1) / 2) * KSIZE + (KSIZE - 1) / 2;
    localparam int PROD_W = PIXEL_WIDTH + COEFF_WIDTH;
    localparam int CNT_W  = $clog2(KSIZE + 1);
    localparam int AW1    = ACCUM_WIDTH + 1;
    localparam logic [CNT_W-1:0]       CNT_FULL  = CNT_W'(KSIZE);
    localparam logic [SHIFT_WIDTH-1:0] RST_SHIFT = SHIFT_WIDTH'(2 * (KSIZE - 1));
    localparam logic [AW1-1:0]         PIX_MAX   = AW1'({PIXEL_WIDTH{1'b1}});

    // Binomial coefficient C(n,k); the running product stays integral.
    function automatic int unsigned binom(input int unsigned n, input int unsigned k);
        int unsigned v;
        v = 32'd1;
        for (int unsigned i = 0; i < k; i++) begin
            v = v * (n - i) / (i + 32'd1);
        end
        return v;
    endfunction

    // Reset coefficient: outer product of the binomial row with itself.
    function automatic logic [COEFF_WIDTH-1:0] rst_coeff(input int idx);
        return COEFF_WIDTH'(binom(KSIZE - 1, idx / KSIZE) * binom(KSIZE - 1, idx % KSIZE));
    endfunction

    logic                    accept_s;
    logic                    complete_s;
    logic                    swap_s;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pending_q, pending_d;
    logic [PIXEL_WIDTH-1:0]  win_q [NTAP];
    logic [COEFF_WIDTH-1:0]  act_coef_q [NTAP];
    logic [COEFF_WIDTH-1:0]  shd_coef_q [NTAP];
    logic [SHIFT_WIDTH-1:0]  act_shift_q, shd_shift_q;

    logic                    win_vld_q;
    logic [PROD_W-1:0]       s1_prod_q [NTAP];
    logic [PIXEL_WIDTH-1:0]  s1_ctr_q;
    logic                    s1_byp_q, s1_vld_q;
    logic [SHIFT_WIDTH-1:0]  s1_shift_q;
    logic [ACCUM_WIDTH-1:0]  sum_s, s2_sum_q;
    logic [PIXEL_WIDTH-1:0]  s2_ctr_q;
    logic                    s2_byp_q, s2_vld_q;
    logic [SHIFT_WIDTH-1:0]  s2_shift_q;
    logic [AW1-1:0]          rnd_s, shifted_s;
    logic [PIXEL_WIDTH-1:0]  sat_s;
    logic [PIXEL_WIDTH-1:0]  pixel_out_q;
    logic                    valid_out_q;

    assign accept_s   = bus.enable & bus.valid_in;
    assign complete_s = accept_s & (cnt_d == CNT_FULL);
    assign swap_s     = accept_s & bus.sol & (pending_q | bus.coeff_commit);

    // Column counter next state; zero means no line started since reset,
    // so only a sol can begin counting.
    always_comb begin
        cnt_d = cnt_q;
        if (accept_s) begin
            if (bus.sol) begin
                cnt_d = CNT_W'(1'b1);
            end else if ((cnt_q == '0) || (cnt_q == CNT_FULL)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1'b1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Commit request next state; a swap wins over a same-cycle commit.
    always_comb begin
        pending_d = pending_q;
        if (swap_s) begin
            pending_d = 1'b0;
        end else if (bus.coeff_commit) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Column counter and commit-pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    // Per-row window shift registers; column 0 is the newest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAP; i++) win_q[i] <= '0;
        end else if (accept_s) begin
            for (int r = 0; r < KSIZE; r++) begin
                win_q[r*KSIZE] <= bus.win_col[r*PIXEL_WIDTH +: PIXEL_WIDTH];
                for (int c = 1; c < KSIZE; c++) begin
                    win_q[r*KSIZE + c] <= win_q[r*KSIZE + c - 1];
                end
            end
        end
    end

    // Shadow bank: written any cycle, out-of-range addresses dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAP; i++) shd_coef_q[i] <= rst_coeff(i);
            shd_shift_q <= RST_SHIFT;
        end else begin
            for (int i = 0; i < NTAP; i++) begin
                if (bus.coeff_wr_en && (bus.coeff_wr_addr == 6'(i))) begin
                    shd_coef_q[i] <= bus.coeff_wr_data;
                end
            end
            if (bus.shift_wr_en) begin
                shd_shift_q <= bus.shift_wr_data;
            end
        end
    end

    // Active bank: takes the pre-edge shadow contents on a line-start swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAP; i++) act_coef_q[i] <= rst_coeff(i);
            act_shift_q <= RST_SHIFT;
        end else if (swap_s) begin
            for (int i = 0; i < NTAP; i++) act_coef_q[i] <= shd_coef_q[i];
            act_shift_q <= shd_shift_q;
        end
    end

    // Stage-2 adder tree input: full-width sum of the stage-1 products.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < NTAP; i++) begin
            sum_s = sum_s + ACCUM_WIDTH'(s1_prod_q[i]);
        end
    end

    // Stage-3 round-half-up, normalising shift and saturation.
    always_comb begin
        rnd_s = {1'b0, s2_sum_q};
        if (s2_shift_q != '0) begin
            rnd_s = rnd_s + (AW1'(1'b1) << (s2_shift_q - SHIFT_WIDTH'(1'b1)));
        end else begin
            rnd_s = {1'b0, s2_sum_q};
        end
        shifted_s = rnd_s >> s2_shift_q;
        if (shifted_s > PIX_MAX) begin
            sat_s = {PIXEL_WIDTH{1'b1}};
        end else begin
            sat_s = shifted_s[PIXEL_WIDTH-1:0];
        end
    end

    // Three-stage pipeline; the shift travels with each token so results
    // already in flight keep the bank they were multiplied with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_vld_q   <= 1'b0;
            for (int i = 0; i < NTAP; i++) s1_prod_q[i] <= '0;
            s1_ctr_q    <= '0;
            s1_byp_q    <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_shift_q  <= '0;
            s2_sum_q    <= '0;
            s2_ctr_q    <= '0;
            s2_byp_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_shift_q  <= '0;
            pixel_out_q <= '0;
            valid_out_q <= 1'b0;
        end else if (bus.enable) begin
            win_vld_q <= complete_s;
            for (int i = 0; i < NTAP; i++) begin
                s1_prod_q[i] <= PROD_W'(win_q[i]) * PROD_W'(act_coef_q[i]);
            end
            s1_ctr_q    <= win_q[CTR];
            s1_byp_q    <= bus.bypass;
            s1_vld_q    <= win_vld_q;
            s1_shift_q  <= act_shift_q;
            s2_sum_q    <= sum_s;
            s2_ctr_q    <= s1_ctr_q;
            s2_byp_q    <= s1_byp_q;
            s2_vld_q    <= s1_vld_q;
            s2_shift_q  <= s1_shift_q;
            pixel_out_q <= s2_byp_q ? s2_ctr_q : sat_s;
            valid_out_q <= s2_vld_q;
        end
    end

    assign bus.pixel_out     = pixel_out_q;
    assign bus.valid_out     = valid_out_q;
    assign bus.coeff_pending = pending_q;
endmodule
